toom_split_eval: RTL and testbench

- Parametrised Toom-K front end: accepts one operand pair (A, B) of WIDTH bits and splits each into K unsigned limbs of LIMB = WIDTH/K bits (limb 0 = LSBs).
- Evaluates both limb polynomials at the 2K-1 Toom points and streams one evaluated pair per point to the pointwise-multiplier stage.
- Successor to the fixed 1024-bit / 8-chunk splitter: width, limb count and evaluation width are generic, and it has valid/ready handshakes and sequential Horner evaluation.

---
 rtl/toom_split_eval_if.sv | 36 +++
 rtl/toom_split_eval.sv | 113 +++++++++++
 tb/tb_toom_split_eval.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/toom_split_eval_if.sv
// toom_split_eval_if: operand/result handshake bundle for toom_split_eval (ovf only with TOOM_SPLIT_OVF_CHECK_EN)
interface toom_split_eval_if #(
  parameter int WIDTH  = 1024,
  parameter int K      = 8,
  parameter int EVAL_W = 152
);
  localparam int PW = $clog2(2*K-1);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [PW-1:0]            out_pt_idx;
  logic signed [EVAL_W-1:0] out_a;
  logic signed [EVAL_W-1:0] out_b;
  logic                     out_last;
  logic                     busy;
`ifdef TOOM_SPLIT_OVF_CHECK_EN
  logic                     ovf;
`endif
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_pt_idx, out_a, out_b, out_last, busy
`ifdef TOOM_SPLIT_OVF_CHECK_EN
    , ovf
`endif
  );
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_pt_idx, out_a, out_b, out_last, busy
`ifdef TOOM_SPLIT_OVF_CHECK_EN
    , ovf
`endif
  );
endinterface

// File: rtl/toom_split_eval.sv
// toom_split_eval: Toom-K limb splitter with sequential Horner evaluation at 0,+1,-1,+2,-2,...,inf.
// Optional TOOM_SPLIT_OVF_CHECK_EN adds a sticky per-pair overflow flag.
module toom_split_eval #(
  parameter int WIDTH  = 1024,
  parameter int K      = 8,
  parameter int EVAL_W = 152
) (
  input logic               clk,
  input logic               rst,
  toom_split_eval_if.slave  bus
);
  localparam int LIMB = WIDTH / K;
  localparam int PW   = $clog2(2*K-1);
  localparam int IW   = $clog2(K);
  localparam int LAST = 2*K-2;
`ifdef TOOM_SPLIT_OVF_CHECK_EN
  localparam int XW   = EVAL_W + 6;
`else
  localparam int XW   = EVAL_W;
`endif
  typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;
  state_t                   state, nxt_state;
  logic [WIDTH-1:0]         a_r, b_r;
  logic [PW-1:0]            j;
  logic [IW-1:0]            i;
  logic signed [EVAL_W-1:0] acc_a, acc_b;
  logic [4:0]               m;
  logic signed [4:0]        p;
  logic                     inf, first;
  logic signed [XW-1:0]     nx_a, nx_b;
`ifdef TOOM_SPLIT_OVF_CHECK_EN
  logic                     ov;
`endif
  // The infinity point just captures the leading limb on the first step and holds it.
  function automatic logic signed [XW-1:0] step(input logic signed [EVAL_W-1:0] acc,
                                                input logic [LIMB-1:0] limb,
                                                input logic signed [4:0] pv,
                                                input logic inf_pt, first_pt);
    logic signed [XW-1:0] z;
    z = $signed({{(XW-LIMB){1'b0}}, limb});
    step = inf_pt ? (first_pt ? z : XW'(acc)) : XW'(acc) * XW'(pv) + z;
  endfunction
  always_comb begin
    inf   = j == PW'(LAST);
    first = i == IW'(K-1);
    m     = 5'((32'(j) + 1) >> 1);
    p     = j[0] ? $signed(m) : -$signed(m);
    nx_a  = step(acc_a, a_r[i*LIMB +: LIMB], p, inf, first);
    nx_b  = step(acc_b, b_r[i*LIMB +: LIMB], p, inf, first);
`ifdef TOOM_SPLIT_OVF_CHECK_EN
    ov    = (nx_a != XW'($signed(nx_a[EVAL_W-1:0]))) || (nx_b != XW'($signed(nx_b[EVAL_W-1:0])));
`endif
    nxt_state = state == IDLE ? (bus.in_valid ? EVAL : IDLE) :
                state == EVAL ? (i == '0 ? OUT : EVAL) :
                (bus.out_ready ? (inf ? IDLE : EVAL) : OUT);
  end
  assign bus.in_ready = state == IDLE;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r            <= '0;
      b_r            <= '0;
      j              <= '0;
      i              <= '0;
      acc_a          <= '0;
      acc_b          <= '0;
      bus.out_a      <= '0;
      bus.out_b      <= '0;
      bus.out_pt_idx <= '0;
      bus.out_last   <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.busy       <= 1'b0;
`ifdef TOOM_SPLIT_OVF_CHECK_EN
      bus.ovf        <= 1'b0;
`endif
    end else begin
      bus.busy <= nxt_state != IDLE;
      if (state == IDLE && bus.in_valid) begin
        a_r   <= bus.in_a;
        b_r   <= bus.in_b;
        j     <= '0;
        i     <= IW'(K-1);
        acc_a <= '0;
        acc_b <= '0;
`ifdef TOOM_SPLIT_OVF_CHECK_EN
        bus.ovf <= 1'b0;
`endif
      end
      if (state == EVAL) begin
        acc_a <= nx_a[EVAL_W-1:0];
        acc_b <= nx_b[EVAL_W-1:0];
        i     <= i - 1'b1;
`ifdef TOOM_SPLIT_OVF_CHECK_EN
        bus.ovf <= bus.ovf | ov;
`endif
        if (i == '0) begin
          bus.out_a      <= nx_a[EVAL_W-1:0];
          bus.out_b      <= nx_b[EVAL_W-1:0];
          bus.out_pt_idx <= j;
          bus.out_last   <= inf;
          bus.out_valid  <= 1'b1;
        end
      end
      if (state == OUT && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        j             <= j + 1'b1;
        i             <= IW'(K-1);
        acc_a         <= '0;
        acc_b         <= '0;
      end
    end
  end
endmodule

// File: tb/tb_toom_split_eval.sv
// tb_toom_split_eval: directed vectors with hand-computed Toom-8 evaluations for toom_split_eval
module tb_toom_split_eval;
  localparam int WIDTH  = 1024;
  localparam int K      = 8;
  localparam int EVAL_W = 149;
  localparam int NPT    = 2*K-1;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  toom_split_eval_if #(.WIDTH(WIDTH), .K(K), .EVAL_W(EVAL_W)) bus();
  toom_split_eval #(.WIDTH(WIDTH), .K(K), .EVAL_W(EVAL_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic signed [EVAL_W-1:0] q_a[$];
  logic signed [EVAL_W-1:0] q_b[$];
  logic [3:0]               q_idx[$];
  logic                     q_last[$];
`ifdef TOOM_SPLIT_OVF_CHECK_EN
  logic                     q_ovf[$];
`endif
  task automatic check(input string tag, input logic signed [255:0] got, input logic signed [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Record every handshake; verify outputs hold steady across stalled cycles.
  initial begin
    logic                     held;
    logic signed [EVAL_W-1:0] h_a, h_b;
    logic [3:0]               h_idx;
    logic                     h_last;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (held && bus.out_valid && !rst) begin
        check("stall_a", bus.out_a, h_a);
        check("stall_b", bus.out_b, h_b);
        check("stall_idx", bus.out_pt_idx, h_idx);
        check("stall_last", bus.out_last, h_last);
      end
      held   = bus.out_valid && !bus.out_ready && !rst;
      h_a    = bus.out_a;
      h_b    = bus.out_b;
      h_idx  = bus.out_pt_idx;
      h_last = bus.out_last;
      if (!rst && bus.out_valid && bus.out_ready) begin
        q_a.push_back(bus.out_a);
        q_b.push_back(bus.out_b);
        q_idx.push_back(bus.out_pt_idx);
        q_last.push_back(bus.out_last);
`ifdef TOOM_SPLIT_OVF_CHECK_EN
        q_ovf.push_back(bus.ovf);
`endif
      end
    end
  end
  task automatic clear_q();
    q_a.delete();
    q_b.delete();
    q_idx.delete();
    q_last.delete();
`ifdef TOOM_SPLIT_OVF_CHECK_EN
    q_ovf.delete();
`endif
  endtask
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit tgl);
    int n;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (tgl) bus.out_ready = ~bus.out_ready;
    end
    check("lat_first", n, K);
    while (!bus.in_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (tgl) bus.out_ready = ~bus.out_ready;
    end
    check("pair_done", bus.in_ready, 1);
    if (!tgl) check("lat_pair", n, NPT*(K+1));
    bus.out_ready = 1'b1;
  endtask
  task automatic chk_run(input string tag);
    check({tag, "_count"}, q_a.size(), NPT);
    for (int k = 0; k < NPT && k < q_a.size(); k++) begin
      check({tag, "_idx"}, q_idx[k], k);
      check({tag, "_last"}, q_last[k], k == NPT-1);
    end
    if (q_a.size() >= NPT) begin
      check({tag, "_j0"}, q_a[0], 253);
      check({tag, "_j1"}, q_a[1], 288);
      check({tag, "_j2"}, q_a[2], 248);
      check({tag, "_j3"}, q_a[3], 2045);
      check({tag, "_j4"}, q_a[4], -459);
      check({tag, "_j14"}, q_a[14], 8);
      check({tag, "_b3"}, q_b[3], 2045);
      check({tag, "_b4"}, q_b[4], -459);
    end
  endtask
  initial begin
    logic [WIDTH-1:0] v, p2a, p2b, ones;
    logic [255:0]     big, lim;
    int               lv[8];
    int               n;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [WIDTH-1:0] v, p2a, p2b, ones;
    logic [255:0]     big, lim;
    int               lv[8];
    int               n;
    lv = '{253, 2, 3, 4, 5, 6, 7, 8};
    v = '0;
    for (int k = 0; k < 8; k++) v[k*128 +: 128] = 128'(lv[k]);
    p2a = '0;
    p2a[0] = 1'b1;
    p2b = '0;
    p2b[1] = 1'b1;
    ones = '1;
    lim = (256'd1 << 128) - 256'd1;
    big = lim * 256'd960800;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_a", bus.out_a, 0);
    check("rst_out_b", bus.out_b, 0);
    check("rst_idx", bus.out_pt_idx, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
`ifdef TOOM_SPLIT_OVF_CHECK_EN
    check("rst_ovf", bus.ovf, 0);
`endif
    clear_q();
    send(v, v, 1'b0);
    chk_run("basic");
    clear_q();
    send(v, v, 1'b1);
    chk_run("stall");
    // Second pair held on the bus throughout; it must wait for the first pair's last handshake.
    clear_q();
    bus.in_a = v;
    bus.in_b = v;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_a = p2a;
    bus.in_b = p2b;
    n = 0;
    while (!bus.in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_accept_lat", n, NPT*(K+1));
    check("hold_busy_idle", bus.busy, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("hold_busy2", bus.busy, 1);
    check("hold_in_ready2", bus.in_ready, 0);
    n = 0;
    while (!bus.in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_count", q_a.size(), 2*NPT);
    if (q_a.size() >= 2*NPT) begin
      check("hold_p1_j3", q_a[3], 2045);
      check("hold_p1_last", q_last[14], 1);
      check("hold_p2_idx0", q_idx[15], 0);
      check("hold_p2_a0", q_a[15], 1);
      check("hold_p2_b0", q_b[15], 2);
      check("hold_p2_a2", q_a[17], 1);
      check("hold_p2_a14", q_a[29], 0);
      check("hold_p2_last", q_last[29], 1);
      check("hold_p2_idx14", q_idx[29], 14);
    end
    // Reset in the middle of point 5.
    clear_q();
    bus.in_a = v;
    bus.in_b = v;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (q_a.size() < 5 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reached_j5", q_a.size(), 5);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_out_a", bus.out_a, 0);
    check("mid_idx", bus.out_pt_idx, 0);
    check("mid_valid", bus.out_valid, 0);
    check("mid_busy", bus.busy, 0);
    check("mid_in_ready", bus.in_ready, 1);
    clear_q();
    repeat (20) @(posedge clk);
    #1;
    check("mid_no_output", q_a.size(), 0);
    send(v, v, 1'b0);
    chk_run("after_rst");
    // All-ones operands at the minimum legal EVAL_W.
    clear_q();
    send(ones, ones, 1'b0);
    check("ones_count", q_a.size(), NPT);
    if (q_a.size() >= NPT) begin
      check("ones_j0", $signed({1'b0, q_a[0]}), lim);
      check("ones_j1", $signed({1'b0, q_a[1]}), lim * 256'd8);
      check("ones_j13_a", $signed({1'b0, q_a[13]}), big);
      check("ones_j13_b", $signed({1'b0, q_b[13]}), big);
      check("ones_j14", $signed({1'b0, q_a[14]}), lim);
`ifdef TOOM_SPLIT_OVF_CHECK_EN
      check("ones_ovf", q_ovf[13], 0);
`endif
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
